// File: rtl/i2c_cmd_master.sv
// Single-byte I2C write master driven by a 16-bit PIO command word (toggle bit 15 to launch).
// Optional SCL clock stretching is compiled in with `define I2C_CLK_STRETCH_EN.
module i2c_cmd_master #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cmd_word,
  input  logic        sda_in,
  input  logic        scl_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        busy,
  output logic        ack_err,
  output logic        done_tgl
);

  // state | meaning
  // IDLE  | lines released, waiting for a go toggle
  // START | start condition, 4 phases
  // ADDR  | 7-bit address + W, MSB first
  // ACK1  | slave ack slot after address
  // DATA  | data byte, MSB first
  // ACK2  | slave ack slot after data
  // STOP  | stop condition, then back to IDLE
  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic [7:0]    data;
  logic          go_prev;
  logic          at_max;
  logic          tick;

  assign at_max = (cnt == CNT_MAX);

`ifdef I2C_CLK_STRETCH_EN
  // SCL is released in every ph1; a slave holding it low freezes the phase at its last count
  assign tick = at_max && !((phase == 2'd1) && !scl_in);
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign tick = at_max;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      phase    <= 2'd0;
      bit_cnt  <= 3'd0;
      sh       <= 8'd0;
      data     <= 8'd0;
      go_prev  <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      ack_err  <= 1'b0;
      done_tgl <= 1'b0;
    end else begin
      go_prev <= cmd_word[15];
      if (state == IDLE) begin
        cnt <= '0;
        if (cmd_word[15] != go_prev) begin
          sh      <= {cmd_word[14:8], 1'b0};
          data    <= cmd_word[7:0];
          ack_err <= 1'b0;
          busy    <= 1'b1;
          phase   <= 2'd0;
          bit_cnt <= 3'd0;
          scl_oe  <= 1'b0;
          sda_oe  <= 1'b0;
          state   <= START;
        end
      end else begin
        if (tick) begin
          cnt   <= '0;
          phase <= phase + 2'd1;
        end else if (!at_max) begin
          cnt <= cnt + 1'b1;
        end

        // Line levels are updated on the tick that enters each phase, so outputs stay registered
        if (tick) begin
          case (state)
            START: begin
              case (phase)
                2'd0: sda_oe <= 1'b1;
                2'd1: scl_oe <= 1'b1;
                2'd3: begin
                  sda_oe <= ~sh[7];
                  state  <= ADDR;
                end
                default: ;
              endcase
            end
            ADDR, DATA: begin
              case (phase)
                2'd0: scl_oe <= 1'b0;
                2'd2: scl_oe <= 1'b1;
                2'd3: begin
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                    sda_oe <= 1'b0;
                    state  <= (state == ADDR) ? ACK1 : ACK2;
                  end else begin
                    sh     <= {sh[6:0], 1'b0};
                    sda_oe <= ~sh[6];
                  end
                end
                default: ;
              endcase
            end
            ACK1, ACK2: begin
              case (phase)
                2'd0: scl_oe <= 1'b0;
                2'd1: if (sda_in) ack_err <= 1'b1;
                2'd2: scl_oe <= 1'b1;
                2'd3: begin
                  // ack_err can only be set by ACK1 here, since it was cleared at launch
                  if ((state == ACK1) && !ack_err) begin
                    sh     <= data;
                    sda_oe <= ~data[7];
                    state  <= DATA;
                  end else begin
                    sda_oe <= 1'b1;
                    state  <= STOP;
                  end
                end
                default: ;
              endcase
            end
            STOP: begin
              case (phase)
                2'd0: scl_oe <= 1'b0;
                2'd1: sda_oe <= 1'b0;
                2'd3: begin
                  busy     <= 1'b0;
                  done_tgl <= ~done_tgl;
                  state    <= IDLE;
                end
                default: ;
              endcase
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule
